// File: rtl/tpu_stage_pipeline_ctrl.sv
// tpu_stage_pipeline_ctrl: in-order stage slot tracker with flush, occupancy and retire stats.
// Define TPU_PIPE_STATS_EN to build the saturating blocked-stage counter on stall_cnt_o.
module tpu_stage_pipeline_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int INSTR_W    = 64,
  parameter int CNT_W      = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            issue_valid_i,
  input  logic [INSTR_W-1:0]              issue_instr_i,
  output logic                            issue_rdy_o,
  input  logic [NUM_STAGES-1:0]           stage_done_i,
  input  logic                            flush_i,
  output logic [NUM_STAGES-1:0]           stage_valid_o,
  output logic [NUM_STAGES*INSTR_W-1:0]   stage_instr_o,
  output logic [$clog2(NUM_STAGES+1)-1:0] occupancy_o,
  output logic                            idle_o,
  output logic                            retire_o,
  output logic [CNT_W-1:0]                retired_cnt_o,
  output logic [CNT_W-1:0]                stall_cnt_o
);
  localparam int OCC_W = $clog2(NUM_STAGES+1);
  logic [NUM_STAGES-1:0] valid_q, valid_d, done_q, done_d, fin, adv;
  logic [NUM_STAGES-1:0][INSTR_W-1:0] instr_q, instr_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [OCC_W-1:0] occ;
  logic accept, free, a;
  assign fin = valid_q & (done_q | stage_done_i);
  // Advance ripples back from the last slot: a slot moves if the next one is empty or moving too.
  always_comb begin
    adv = '0;
    free = 1'b1;
    a = 1'b0;
    for (int k = NUM_STAGES-1; k >= 0; k--) begin
      a = fin[k] & free;
      adv[k] = a;
      free = !valid_q[k] | a;
    end
  end
  assign issue_rdy_o = !flush_i & (!valid_q[0] | adv[0]);
  assign accept = issue_valid_i & issue_rdy_o;
  assign retire_o = adv[NUM_STAGES-1] & !flush_i;
  always_comb begin
    valid_d = valid_q;
    done_d = (done_q | stage_done_i) & valid_q;
    instr_d = instr_q;
    if (accept) begin
      valid_d[0] = 1'b1;
      done_d[0] = 1'b0;
      instr_d[0] = issue_instr_i;
    end else if (adv[0]) begin
      valid_d[0] = 1'b0;
      done_d[0] = 1'b0;
    end
    for (int k = 1; k < NUM_STAGES; k++) begin
      if (adv[k-1]) begin
        valid_d[k] = 1'b1;
        done_d[k] = 1'b0;
        instr_d[k] = instr_q[k-1];
      end else if (adv[k]) begin
        valid_d[k] = 1'b0;
        done_d[k] = 1'b0;
      end
    end
    if (flush_i) begin
      valid_d = '0;
      done_d = '0;
    end
    retired_d = retired_q + CNT_W'(retire_o);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      done_q <= '0;
      instr_q <= '0;
      retired_q <= '0;
    end else begin
      valid_q <= valid_d;
      done_q <= done_d;
      instr_q <= instr_d;
      retired_q <= retired_d;
    end
  end
  always_comb begin
    occ = '0;
    for (int k = 0; k < NUM_STAGES; k++) occ = occ + OCC_W'(valid_q[k]);
  end
  assign occupancy_o = occ;
  assign idle_o = (occ == '0);
  assign stage_valid_o = valid_q;
  assign stage_instr_o = instr_q;
  assign retired_cnt_o = retired_q;
`ifdef TPU_PIPE_STATS_EN
  logic [CNT_W-1:0] stall_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stall_q <= '0;
    else if (|(fin & ~adv) && !(&stall_q)) stall_q <= stall_q + CNT_W'(1);
  end
  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_tpu_stage_pipeline_ctrl.sv
// tb_tpu_stage_pipeline_ctrl: directed stimulus with a retire scoreboard for tpu_stage_pipeline_ctrl.
module tb_tpu_stage_pipeline_ctrl;
  localparam int N = 4;
  localparam int W = 64;
  localparam int C = 16;
`ifdef TPU_PIPE_STATS_EN
  localparam logic STATS = 1'b1;
`else
  localparam logic STATS = 1'b0;
`endif
  logic clk_i = 1'b0, rst_i = 1'b1;
  logic issue_valid_i = 1'b0, flush_i = 1'b0;
  logic [W-1:0] issue_instr_i = '0;
  logic [N-1:0] stage_done_i = '0;
  logic issue_rdy_o, idle_o, retire_o;
  logic [N-1:0] stage_valid_o;
  logic [N*W-1:0] stage_instr_o;
  logic [2:0] occupancy_o;
  logic [C-1:0] retired_cnt_o, stall_cnt_o;
  logic [W-1:0] exp_q [$];
  int pass_cnt = 0, total_cnt = 0;
  localparam logic [W-1:0] S  = 64'h5151_0000_0000_0001;
  localparam logic [W-1:0] F1 = 64'hF1F1_0000_0000_00A1;
  localparam logic [W-1:0] F2 = 64'hF2F2_0000_0000_00B2;
  localparam logic [W-1:0] F3 = 64'hF3F3_0000_0000_00C3;
  localparam logic [W-1:0] F4 = 64'hF4F4_0000_0000_00D4;
  localparam logic [W-1:0] E  = 64'hEEEE_0000_0000_00E5;
  localparam logic [W-1:0] X  = 64'h9999_0000_0000_00F6;
  localparam logic [W-1:0] G  = 64'h6666_0000_0000_0007;

  tpu_stage_pipeline_ctrl #(.NUM_STAGES(N), .INSTR_W(W), .CNT_W(C)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .issue_valid_i(issue_valid_i), .issue_instr_i(issue_instr_i),
    .issue_rdy_o(issue_rdy_o), .stage_done_i(stage_done_i), .flush_i(flush_i),
    .stage_valid_o(stage_valid_o), .stage_instr_o(stage_instr_o), .occupancy_o(occupancy_o),
    .idle_o(idle_o), .retire_o(retire_o), .retired_cnt_o(retired_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] ins, input logic [N-1:0] sd, input logic fl);
    @(posedge clk_i);
    #1;
    issue_valid_i = iv;
    issue_instr_i = ins;
    stage_done_i = sd;
    flush_i = fl;
    #1;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && retire_o) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL retire_unexpected: got instr %h expected no retire at %0t", stage_instr_o[(N-1)*W +: W], $time);
      end else chk("retire_instr", stage_instr_o[(N-1)*W +: W], exp_q.pop_front());
    end
  end

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_valid", W'(stage_valid_o), 0);
    chk("rst_rdy", W'(issue_rdy_o), 1);
    chk("rst_idle", W'(idle_o), 1);
    chk("rst_retire", W'(retire_o), 0);
    chk("rst_retired_cnt", W'(retired_cnt_o), 0);
    chk("rst_stall_cnt", W'(stall_cnt_o), 0);
    rst_i = 1'b0;
    // single instruction walks the pipe
    drive(1'b1, S, 4'b0000, 1'b0);
    chk("single_rdy", W'(issue_rdy_o), 1);
    exp_q.push_back(S);
    drive(1'b0, '0, 4'b0001, 1'b0);
    chk("walk0", W'(stage_valid_o), 4'b0001);
    drive(1'b0, '0, 4'b0010, 1'b0);
    chk("walk1", W'(stage_valid_o), 4'b0010);
    drive(1'b0, '0, 4'b0100, 1'b0);
    chk("walk2", W'(stage_valid_o), 4'b0100);
    drive(1'b0, '0, 4'b1000, 1'b0);
    chk("walk3", W'(stage_valid_o), 4'b1000);
    chk("single_retire", W'(retire_o), 1);
    drive(1'b0, '0, 4'b0000, 1'b0);
    chk("single_idle", W'(idle_o), 1);
    chk("single_retired_cnt", W'(retired_cnt_o), 1);
    chk("single_retire_off", W'(retire_o), 0);
    // fill four, then all stages finish together
    drive(1'b1, F1, 4'b0000, 1'b0);
    exp_q.push_back(F1);
    drive(1'b1, F2, 4'b0001, 1'b0);
    chk("fill_rdy", W'(issue_rdy_o), 1);
    exp_q.push_back(F2);
    drive(1'b1, F3, 4'b0011, 1'b0);
    drive(1'b1, F4, 4'b0111, 1'b0);
    drive(1'b1, E, 4'b0000, 1'b0);
    chk("full_occ", W'(occupancy_o), 4);
    chk("full_rdy", W'(issue_rdy_o), 0);
    chk("full_slot3", stage_instr_o[3*W +: W], F1);
    chk("full_slot0", stage_instr_o[0 +: W], F4);
    drive(1'b1, E, 4'b1111, 1'b0);
    chk("shift_rdy", W'(issue_rdy_o), 1);
    chk("shift_retire", W'(retire_o), 1);
    drive(1'b0, '0, 4'b0000, 1'b0);
    chk("shift_occ", W'(occupancy_o), 4);
    chk("shift_slot3", stage_instr_o[3*W +: W], F2);
    chk("shift_slot0", stage_instr_o[0 +: W], E);
    chk("shift_retired_cnt", W'(retired_cnt_o), 2);
    // slot 2 done while slot 3 busy
    drive(1'b0, '0, 4'b0100, 1'b0);
    drive(1'b0, '0, 4'b0000, 1'b0);
    chk("blocked_valid", W'(stage_valid_o), 4'b1111);
    chk("blocked_stall1", W'(stall_cnt_o), STATS ? 1 : 0);
    drive(1'b0, '0, 4'b1000, 1'b0);
    chk("blocked_stall2", W'(stall_cnt_o), STATS ? 2 : 0);
    chk("blocked_retire", W'(retire_o), 1);
    drive(1'b0, '0, 4'b0000, 1'b0);
    chk("unblocked_valid", W'(stage_valid_o), 4'b1011);
    chk("unblocked_slot3", stage_instr_o[3*W +: W], F3);
    chk("unblocked_retired_cnt", W'(retired_cnt_o), 3);
    chk("unblocked_stall", W'(stall_cnt_o), STATS ? 2 : 0);
    // done on an empty slot is ignored
    drive(1'b0, '0, 4'b0100, 1'b0);
    chk("empty_done_retire", W'(retire_o), 0);
    drive(1'b0, '0, 4'b0000, 1'b0);
    chk("empty_done_valid", W'(stage_valid_o), 4'b1011);
    chk("empty_done_stall", W'(stall_cnt_o), STATS ? 2 : 0);
    // flush with a concurrent issue and finishing last stage
    drive(1'b1, X, 4'b1000, 1'b1);
    chk("flush_rdy", W'(issue_rdy_o), 0);
    chk("flush_retire", W'(retire_o), 0);
    drive(1'b0, '0, 4'b0000, 1'b0);
    chk("flush_occ", W'(occupancy_o), 0);
    chk("flush_idle", W'(idle_o), 1);
    chk("flush_retired_cnt", W'(retired_cnt_o), 3);
    chk("flush_stall", W'(stall_cnt_o), STATS ? 2 : 0);
    // async reset between edges
    drive(1'b1, G, 4'b0000, 1'b0);
    drive(1'b0, '0, 4'b0001, 1'b0);
    chk("pre_rst_valid", W'(stage_valid_o), 4'b0001);
    rst_i = 1'b1;
    #1;
    chk("async_rst_valid", W'(stage_valid_o), 0);
    chk("async_rst_retired_cnt", W'(retired_cnt_o), 0);
    chk("async_rst_idle", W'(idle_o), 1);
    chk("async_rst_rdy", W'(issue_rdy_o), 1);
    chk("async_rst_stall", W'(stall_cnt_o), 0);
    stage_done_i = '0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    repeat (3) drive(1'b0, '0, 4'b0000, 1'b0);
    chk("scoreboard_drained", W'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
